// File: rtl/red_pitaya_dac_slew.sv
// DAC output conditioning: per-cycle slew limiting plus soft mute/unmute ramps
// between an ASG channel sample stream and the DAC pins.
module red_pitaya_dac_slew #(
  parameter int unsigned DW = 14,
  parameter int unsigned CW = 16
) (
  input  logic          dac_clk_i,
  input  logic          dac_rst_i,
  input  logic [DW-1:0] dat_i,
  input  logic          mute_i,
  input  logic          hold_i,
  input  logic [DW-1:0] set_slew_i,
  input  logic [DW-1:0] set_ramp_i,
  input  logic          cnt_clr_i,
  output logic [DW-1:0] dac_o,
  output logic          slewing_o,
  output logic          muted_o,
  output logic [1:0]    state_o,
  output logic [CW-1:0] slew_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUTING   = 2'd1,
    ST_MUTED    = 2'd2,
    ST_UNMUTING = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  dac_q, dac_d;
  logic           slewing_q, slewing_d;
  logic           muted_q, muted_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [DW-1:0]  target;
  logic [DW-1:0]  step;
  logic [DW-1:0]  upd;
  logic signed [DW:0] diff;
  logic signed [DW:0] step_x;
  logic           limited;
  state_e         state_upd;

  always_comb begin
    target = (state_q == ST_RUN || state_q == ST_UNMUTING) ? dat_i : '0;
    step   = (state_q == ST_RUN) ? set_slew_i : set_ramp_i;
    step_x = $signed({1'b0, step});
    // One extra bit so a full-scale jump (e.g. 8191 -> -8192) cannot wrap.
    diff   = $signed({target[DW-1], target}) - $signed({dac_q[DW-1], dac_q});

    upd     = target;
    limited = 1'b0;
    if (step != '0 && diff > step_x) begin
      upd     = dac_q + step;
      limited = 1'b1;
    end else if (step != '0 && diff < -step_x) begin
      upd     = dac_q - step;
      limited = 1'b1;
    end

    // Mute level changes are checked before the landing conditions.
    state_upd = state_q;
    case (state_q)
      ST_RUN:      if (mute_i) state_upd = ST_MUTING;
      ST_MUTING:   if (!mute_i) state_upd = ST_UNMUTING;
                   else if (upd == '0) state_upd = ST_MUTED;
      ST_MUTED:    if (!mute_i) state_upd = ST_UNMUTING;
      ST_UNMUTING: if (mute_i) state_upd = ST_MUTING;
                   else if (!limited) state_upd = ST_RUN;
      default:     state_upd = ST_MUTED;
    endcase

    dac_d     = dac_q;
    state_d   = state_q;
    slewing_d = slewing_q;
    muted_d   = muted_q;
    if (!hold_i) begin
      dac_d     = upd;
      state_d   = state_upd;
      slewing_d = limited;
      muted_d   = (state_upd == ST_MUTED);
    end

    cnt_d = cnt_q;
    if (cnt_clr_i)
      cnt_d = '0;
    else if (!hold_i && state_q == ST_RUN && limited && cnt_q != '1)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      dac_q     <= '0;
      state_q   <= ST_MUTED;
      slewing_q <= 1'b0;
      muted_q   <= 1'b1;
      cnt_q     <= '0;
    end else begin
      dac_q     <= dac_d;
      state_q   <= state_d;
      slewing_q <= slewing_d;
      muted_q   <= muted_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dac_o      = dac_q;
  assign slewing_o  = slewing_q;
  assign muted_o    = muted_q;
  assign state_o    = state_q;
  assign slew_cnt_o = cnt_q;

endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// Scoreboard bench for red_pitaya_dac_slew: directed scenarios followed by
// randomized traffic, checked against an integer reference model.
module tb_red_pitaya_dac_slew;

  localparam int DW = 14;
  localparam int CW = 6;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int M_RUN = 0, M_MUTING = 1, M_MUTED = 2, M_UNMUTING = 3;

  logic          clk = 1'b0;
  logic          rst, mute, hold, clr;
  logic [DW-1:0] dat, slew, ramp;
  logic [DW-1:0] dac;
  logic          slewing, muted;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  red_pitaya_dac_slew #(.DW(DW), .CW(CW)) dut (
    .dac_clk_i (clk),
    .dac_rst_i (rst),
    .dat_i     (dat),
    .mute_i    (mute),
    .hold_i    (hold),
    .set_slew_i(slew),
    .set_ramp_i(ramp),
    .cnt_clr_i (clr),
    .dac_o     (dac),
    .slewing_o (slewing),
    .muted_o   (muted),
    .state_o   (state),
    .slew_cnt_o(cnt)
  );

  typedef struct {
    string tag;
    int    dac;
    int    slw;
    int    mut;
    int    st;
    int    cnt;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  string tag   = "init";

  // Current stimulus settings (integers, samples signed).
  bit s_rst, s_mute, s_hold, s_clr;
  int s_dat, s_slew, s_ramp;

  // Reference model state.
  int m_dac = 0, m_mode = M_MUTED, m_slw = 0, m_mut = 1, m_cnt = 0;

  task automatic model_edge();
    int tgt, stp, d, nv, lim, nm;
    if (s_rst) begin
      m_dac = 0; m_mode = M_MUTED; m_slw = 0; m_mut = 1; m_cnt = 0;
      return;
    end
    tgt = (m_mode == M_RUN || m_mode == M_UNMUTING) ? s_dat : 0;
    stp = (m_mode == M_RUN) ? s_slew : s_ramp;
    d   = tgt - m_dac;
    if (stp != 0 && d > stp)       begin nv = m_dac + stp; lim = 1; end
    else if (stp != 0 && d < -stp) begin nv = m_dac - stp; lim = 1; end
    else                           begin nv = tgt;         lim = 0; end
    nm = m_mode;
    if (m_mode == M_RUN && s_mute)             nm = M_MUTING;
    else if (m_mode == M_MUTING)               nm = !s_mute ? M_UNMUTING : (nv == 0 ? M_MUTED : M_MUTING);
    else if (m_mode == M_MUTED && !s_mute)     nm = M_UNMUTING;
    else if (m_mode == M_UNMUTING)             nm = s_mute ? M_MUTING : (lim == 0 ? M_RUN : M_UNMUTING);
    if (s_clr) m_cnt = 0;
    else if (!s_hold && m_mode == M_RUN && lim == 1 && m_cnt < CNT_MAX) m_cnt++;
    if (!s_hold) begin
      m_dac = nv; m_mode = nm; m_slw = lim; m_mut = (nm == M_MUTED) ? 1 : 0;
    end
  endtask

  task automatic tick(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst  = s_rst;  mute = s_mute; hold = s_hold; clr = s_clr;
      dat  = DW'(s_dat); slew = DW'(s_slew); ramp = DW'(s_ramp);
      model_edge();
      e.tag = tag; e.dac = m_dac; e.slw = m_slw; e.mut = m_mut; e.st = m_mode; e.cnt = m_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic chk(input string t, input string f, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s %s got=%0d want=%0d (t=%0t)", t, f, got, want, $time);
    end
  endtask

  // Monitor: the DUT presents a new output every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "dac_o",      int'($signed(dac)), e.dac);
        chk(e.tag, "slewing_o",  int'(slewing),      e.slw);
        chk(e.tag, "muted_o",    int'(muted),        e.mut);
        chk(e.tag, "state_o",    int'(state),        e.st);
        chk(e.tag, "slew_cnt_o", int'(cnt),          e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; mute = 1'b0; hold = 1'b0; clr = 1'b0; dat = '0; slew = '0; ramp = '0;
    s_rst = 1; s_mute = 0; s_hold = 0; s_clr = 0; s_dat = 0; s_slew = 0; s_ramp = 0;

    tag = "reset";    tick(2);
    s_rst = 0;
    tag = "powerup";  s_ramp = 100; s_dat = 1000; tick(13);
    tag = "unlim";    s_dat = 0; tick(2); s_dat = -8192; tick(2);
    tag = "slew_pos"; s_slew = 1000; s_dat = 0; tick(10); s_dat = 8191; tick(10);
    tag = "slew_neg"; s_dat = -8192; tick(18);
    tag = "fullscale";
    s_slew = 0; s_dat = 8191; tick(2);
    s_slew = 16383; s_dat = -8192; tick(2);
    s_slew = 0; s_dat = 8191; tick(1);
    s_slew = 1000; s_dat = -8192; tick(3);
    tag = "cnt_sat";  s_slew = 1; s_dat = 8191; tick(80);
    tag = "cnt_clr";  s_clr = 1; tick(1); s_clr = 0; tick(2);
    tag = "mute";     s_slew = 0; s_dat = 500; tick(2);
    s_ramp = 200; s_mute = 1; tick(2);
    s_mute = 0; tick(6);
    s_mute = 1; tick(6);
    tag = "hold";     s_mute = 0; tick(6);
    s_mute = 1; tick(2);
    s_hold = 1; tick(3);
    s_hold = 0; tick(1);
    tag = "rst_mid";  s_rst = 1; tick(1); s_rst = 0; tick(3);

    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      s_rst  = ($urandom_range(0, 299) == 0);
      s_hold = ($urandom_range(0, 9) == 0);
      s_clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) s_mute = !s_mute;
      if ($urandom_range(0, 7) == 0) s_dat = int'($urandom_range(0, 16383)) - 8192;
      if (i % 50 == 0) begin
        s_slew = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3000));
        s_ramp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 3000));
      end
      tick(1);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/red_pitaya_dac_slew.md
Name: red_pitaya_dac_slew

Overview:
Output conditioning stage between an ASG channel's 14-bit signed sample output and the DAC pins. It limits the per-cycle slew of the sample stream and provides soft mute/unmute ramps, so waveform switches, buffer swaps and mute requests never drive full-scale steps into the DAC. One instance is used per DAC channel, in the DAC clock domain, directly fed by the channel's dac_o.

Parameters:
DW, 14, sample width (two's complement)
CW, 16, slew-event counter width

Ports:
dac_clk_i  in  1  DAC clock
dac_rst_i  in  1  synchronous reset, active high
dat_i  in  DW  signed input sample from ASG channel, valid every cycle
mute_i  in  1  level: 1 = ramp to zero and stay muted
hold_i  in  1  freeze output and state
set_slew_i  in  DW  unsigned max step per cycle in RUN; 0 = unlimited
set_ramp_i  in  DW  unsigned step per cycle during MUTING/UNMUTING; 0 = immediate
cnt_clr_i  in  1  clear slew-event counter
dac_o  out  DW  signed conditioned sample to DAC
slewing_o  out  1  1 = step was limited this update
muted_o  out  1  1 = state MUTED
state_o  out  2  FSM state
slew_cnt_o  out  CW  saturating count of limited cycles in RUN

Behaviour:
- Reset (dac_rst_i=1 on edge): dac_o=0, state=MUTED, muted_o=1, slewing_o=0, slew_cnt_o=0. Reset wins over all other inputs, including mid-ramp.
- State encoding: RUN=0, MUTING=1, MUTED=2, UNMUTING=3.
- Target selection: RUN and UNMUTING use target=dat_i. MUTING and MUTED use target=0.
- Step selection: RUN uses set_slew_i. MUTING and UNMUTING use set_ramp_i. A step of 0 means unlimited.
- Update arithmetic:
  - diff = target - dac_o, computed sign-extended to DW+1 bits; step is zero-extended to DW+1.
  - If step!=0 and diff>step: dac_o += step, limited=1.
  - If step!=0 and diff<-step: dac_o -= step, limited=1.
  - Otherwise: dac_o = target, limited=0.
  - The result never overflows DW.
- Latency: dat_i to dac_o is 1 cycle when unlimited.
- slewing_o is registered with the dac_o update and equals limited.
- Transitions, evaluated each edge with the dac_o update:
  - RUN: mute_i=1 -> MUTING; the ramp starts on the next edge.
  - MUTING: mute_i=0 -> UNMUTING. Else, if the new dac_o==0 -> MUTED, with muted_o=1 on the same edge.
  - MUTED: dac_o held at 0. mute_i=0 -> UNMUTING.
  - UNMUTING: mute_i=1 -> MUTING. Else, if limited=0 on this update (output landed on dat_i) -> RUN.
- Transition priority: mute_i changes take priority over landing conditions in the same cycle.
- muted_o = (next state==MUTED), registered.
- hold_i=1: dac_o, state, slewing_o and the counter all keep their values. cnt_clr_i still clears the counter. hold has lower priority than reset.
- slew_cnt_o:
  - Increments when state==RUN, limited=1 and hold_i=0.
  - Saturates at all-ones.
  - cnt_clr_i=1 clears it to 0, with priority over a same-cycle increment.
- Settings changes take effect on the next edge; there is no shadowing.

Test Plan:
1. Power-up ramp: reset, then mute_i=0, set_ramp_i=100, dat_i=1000 -> edge 1: state UNMUTING, dac_o=0; then dac_o=100,200,...,1000; state=RUN on the edge where dac_o=1000; slewing_o=1 for the nine steps 100..900, 0 at 1000.
2. Unlimited path: RUN, set_slew_i=0, dat_i 0 -> -8192 -> dac_o=-8192 one cycle later; slewing_o=0; slew_cnt_o unchanged.
3. Slew limit: RUN, set_slew_i=1000, dat_i 0 -> 8191 -> dac_o=1000,2000,...,8000,8191; slewing_o high 8 cycles; slew_cnt_o=8. Repeat with -8192 and full-scale jump 8191 -> -8192 (diff -16383), checking no wrap.
4. Mute/unmute: RUN with dac_o=500, set_ramp_i=200, mute_i=1 -> MUTING, then dac_o=300,100,0, with muted_o=1 on the edge dac_o=0. Release mute_i when dac_o=300 -> UNMUTING, and dac_o ramps back toward dat_i.
5. Counter edges: force slew_cnt_o to 0xFFFF -> further limited cycles keep 0xFFFF; cnt_clr_i with a same-cycle limited step -> 0.
6. Hold and reset mid-operation: hold_i=1 during MUTING -> dac_o and state frozen. Release -> ramp resumes. Assert dac_rst_i mid-ramp -> next edge dac_o=0, state=MUTED, counter=0.
